freelist_checkpoint_ctrl: RTL and testbench
===========================================

Name: freelist_checkpoint_ctrl

Overview:
Manages branch checkpoints of the speculative free-list head pointer for the rename stage. Allocates one checkpoint per renamed branch into an in-order ring and tracks out-of-order resolution. On a mispredict it squashes the offending checkpoint and all younger ones. It then drives the restored head plus a one-cycle recovery strobe into the speculative free list (its freeListHeadCp / ctrlVerified&flagRecoverEX inputs).

Parameters:
NUM_CP, 8, number of checkpoint entries (power of two)
CP_LOG, 3, log2(NUM_CP); width of checkpoint IDs and ring pointers
FL_LOG, 7, width of a free-list head pointer

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
alloc_req_i  input  1  a branch is being renamed this cycle and needs a checkpoint
alloc_head_i  input  FL_LOG  free-list head value to snapshot for that branch
alloc_grant_o  output  1  checkpoint allocated this cycle (combinational)
alloc_id_o  output  CP_LOG  ID of the granted checkpoint (= tail pointer)
stall_o  output  1  ring full; rename must stall branches
resolve_valid_i  input  1  branch resolution event
resolve_id_i  input  CP_LOG  checkpoint ID being resolved
resolve_mispred_i  input  1  resolution is a mispredict
flush_i  input  1  full pipeline recovery (commit-time exception/recover)
cp_restore_o  output  1  one-cycle pulse: restore free-list head
cp_head_o  output  FL_LOG  head value to restore (valid when cp_restore_o=1)
occupancy_o  output  CP_LOG+1  live checkpoint count

Behaviour:
- State: head_ptr, tail_ptr (CP_LOG bits, wrap modulo NUM_CP); count (CP_LOG+1 bits); per entry snap[FL_LOG], live, done.
- Reset: head_ptr=tail_ptr=0, count=0, all live/done=0, cp_restore_o=0, cp_head_o=0. Reset overrides every other input.
- stall_o = (count==NUM_CP). alloc_grant_o = alloc_req_i & ~stall_o & ~flush_i & ~(resolve_valid_i & resolve_mispred_i & live[resolve_id_i]). alloc_id_o = tail_ptr.
- Grant: snap[tail]<=alloc_head_i, live=1, done=0, tail_ptr+1.
- Correct resolve (valid, ~mispred, live[id]): done[id]<=1. Resolves of non-live IDs are ignored.
- Retire: each cycle, if count>0 and done[head_ptr] (registered value), clear live/done, head_ptr+1. At most one retire per cycle.
- Mispredict (valid, mispred, live[id]=k): cp_restore_o<=1 and cp_head_o<=snap[k] on the next cycle, so latency is 1. Clear live/done for every entry from k up to tail-1, modulo wrap. tail_ptr<=k. count<=(k-head_ptr) mod NUM_CP, adjusted -1 if a retire of head fires in the same cycle. If k==head_ptr, the ring is emptied.
- A same-cycle alloc is blocked by the mispredict, which wins. The same-cycle retire still applies.
- flush_i: all entries invalid, head_ptr=tail_ptr=0, count=0. cp_restore_o stays 0, because the free list handles its own full recovery. flush_i wins over mispredict and alloc.
- count update otherwise: count + grant - retire. A simultaneous grant and retire leaves the count unchanged. A full ring with a retire still stalls this cycle, because stall_o is based on the registered count.
- cp_restore_o is a single-cycle pulse. Back-to-back mispredicts produce consecutive pulses, each carrying its own snapshot.
- occupancy_o = count.

Decomposition:
- Shared package: NUM_CP, CP_LOG, FL_LOG defaults, and the ring-pointer increment/distance function (modulo NUM_CP).
- One sub-module is natural: cp_squash_mask. It is combinational and takes (head_ptr, tail_ptr, k). It outputs an NUM_CP-bit mask of entries from k to tail-1 with wrap handling.
- Everything else is inline.

Test Plan:
- Reset, then 8 allocs with heads 10..17 -> IDs 0..7 granted, stall_o=1 after the 8th, and a 9th alloc_req gives grant=0 and occupancy=8.
- Resolve ID 3 correct, then ID 0 correct -> ID 0 retires one cycle later. Head stops at 1 (ID 1 not done), so occupancy goes 8→7.
- From 5 live (IDs 0..4, heads 20..24), mispredict ID 2 -> next cycle cp_restore_o=1 with cp_head_o=22. tail=2, occupancy=2, and the next alloc gets ID 2.
- Wrap case: head_ptr=6, tail_ptr=2 (IDs 6,7,0,1 live), mispredict ID 7 -> IDs 7,0,1 squashed, tail=7, occupancy=1.
- Mispredict and alloc_req in the same cycle -> alloc_grant_o=0 and the restore pulse is correct. A later resolve of a squashed ID is ignored.
- flush_i with 4 live entries, a simultaneous mispredict and an alloc -> occupancy=0, cp_restore_o stays 0, and the next alloc gets ID 0.

Source files
------------

// File: rtl/freelist_checkpoint_ctrl_pkg.sv
// Shared sizing and ring-pointer helpers for the free-list checkpoint controller.
// Pointers wrap modulo NUM_CP, so plain CP_LOG-bit arithmetic does the wrap.
package freelist_checkpoint_ctrl_pkg;

    localparam int NUM_CP = 8;
    localparam int CP_LOG = 3;
    localparam int FL_LOG = 7;

    typedef logic [CP_LOG-1:0] cp_ptr_t;

    function automatic cp_ptr_t ptr_inc(input cp_ptr_t p);
        return p + cp_ptr_t'(1);
    endfunction

    // Number of steps forward from 'from' to reach 'to', modulo NUM_CP.
    function automatic cp_ptr_t ptr_dist(input cp_ptr_t from, input cp_ptr_t to);
        return to - from;
    endfunction

endpackage

// File: rtl/freelist_checkpoint_ctrl_cp_squash_mask.sv
// Combinational mask of ring entries from k up to tail-1, handling wrap.
// A full ring (tail == head) squashed at its oldest entry selects every entry.
module cp_squash_mask
    import freelist_checkpoint_ctrl_pkg::*;
(
    input  cp_ptr_t           head_ptr,
    input  cp_ptr_t           tail_ptr,
    input  cp_ptr_t           k,
    output logic [NUM_CP-1:0] mask
);

    logic all_entries;

    assign all_entries = (tail_ptr == head_ptr) && (k == tail_ptr);

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            if (all_entries || (ptr_dist(k, cp_ptr_t'(i)) < ptr_dist(k, tail_ptr))) begin
                mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/freelist_checkpoint_ctrl.sv
// Branch checkpoint ring for the speculative free-list head pointer: allocate,
// resolve out of order, retire in order, and restore the head on mispredict.
module freelist_checkpoint_ctrl
    import freelist_checkpoint_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req_i,
    input  logic [FL_LOG-1:0] alloc_head_i,
    output logic              alloc_grant_o,
    output logic [CP_LOG-1:0] alloc_id_o,
    output logic              stall_o,
    input  logic              resolve_valid_i,
    input  logic [CP_LOG-1:0] resolve_id_i,
    input  logic              resolve_mispred_i,
    input  logic              flush_i,
    output logic              cp_restore_o,
    output logic [FL_LOG-1:0] cp_head_o,
    output logic [CP_LOG:0]   occupancy_o
);

    cp_ptr_t           head_ptr;
    cp_ptr_t           tail_ptr;
    logic [CP_LOG:0]   count;
    logic [FL_LOG-1:0] snap [NUM_CP];
    logic [NUM_CP-1:0] live;
    logic [NUM_CP-1:0] done;
    logic [NUM_CP-1:0] squash;
    logic [NUM_CP-1:0] live_next;
    logic [NUM_CP-1:0] done_next;
    logic              mispred;
    logic              good_resolve;
    logic              retire;
    logic              grant;
    logic [CP_LOG:0]   count_next;

    assign mispred      = resolve_valid_i & resolve_mispred_i & live[resolve_id_i];
    assign good_resolve = resolve_valid_i & ~resolve_mispred_i & live[resolve_id_i];
    assign stall_o      = (count == (CP_LOG+1)'(NUM_CP));
    assign grant        = alloc_req_i & ~stall_o & ~flush_i & ~mispred;

    // Squashing the head itself empties the ring, so its retire must not also fire.
    assign retire = (count != '0) & done[head_ptr] & ~(mispred & (resolve_id_i == head_ptr));

    assign alloc_grant_o = grant;
    assign alloc_id_o    = tail_ptr;
    assign occupancy_o   = count;

    cp_squash_mask u_squash (
        .head_ptr (head_ptr),
        .tail_ptr (tail_ptr),
        .k        (resolve_id_i),
        .mask     (squash)
    );

    always_comb begin
        live_next = live;
        done_next = done;
        if (good_resolve) begin
            done_next[resolve_id_i] = 1'b1;
        end
        if (retire) begin
            live_next[head_ptr] = 1'b0;
            done_next[head_ptr] = 1'b0;
        end
        if (mispred) begin
            live_next = live_next & ~squash;
            done_next = done_next & ~squash;
        end
        if (grant) begin
            live_next[tail_ptr] = 1'b1;
            done_next[tail_ptr] = 1'b0;
        end
    end

    always_comb begin
        if (mispred) begin
            count_next = {1'b0, ptr_dist(head_ptr, resolve_id_i)} - (CP_LOG+1)'(retire);
        end else begin
            count_next = count + (CP_LOG+1)'(grant) - (CP_LOG+1)'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            live         <= '0;
            done         <= '0;
            cp_restore_o <= 1'b0;
            cp_head_o    <= '0;
        end else if (flush_i) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            live         <= '0;
            done         <= '0;
            cp_restore_o <= 1'b0;
        end else begin
            live         <= live_next;
            done         <= done_next;
            count        <= count_next;
            cp_restore_o <= mispred;
            if (mispred) begin
                cp_head_o <= snap[resolve_id_i];
                tail_ptr  <= resolve_id_i;
            end else if (grant) begin
                tail_ptr  <= ptr_inc(tail_ptr);
            end
            if (retire) begin
                head_ptr <= ptr_inc(head_ptr);
            end
        end
    end

    // Snapshot storage needs no reset; an entry is only read while live.
    always_ff @(posedge clk) begin
        if (grant) begin
            snap[tail_ptr] <= alloc_head_i;
        end
    end

endmodule

// File: tb/tb_freelist_checkpoint_ctrl.sv
// Directed and randomized checks of freelist_checkpoint_ctrl against a
// queue-based model of the checkpoint ring (oldest entry first).
module tb_freelist_checkpoint_ctrl;

    logic       clk;
    logic       reset;
    logic       alloc_req;
    logic [6:0] alloc_head;
    logic       alloc_grant;
    logic [2:0] alloc_id;
    logic       stall;
    logic       resolve_valid;
    logic [2:0] resolve_id;
    logic       resolve_mispred;
    logic       flush;
    logic       cp_restore;
    logic [6:0] cp_head;
    logic [3:0] occupancy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int id;
        int snap;
        bit done;
    } ent_t;

    ent_t q[$];
    int   mhead;
    bit   exp_restore;
    int   exp_head;

    freelist_checkpoint_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .alloc_req_i       (alloc_req),
        .alloc_head_i      (alloc_head),
        .alloc_grant_o     (alloc_grant),
        .alloc_id_o        (alloc_id),
        .stall_o           (stall),
        .resolve_valid_i   (resolve_valid),
        .resolve_id_i      (resolve_id),
        .resolve_mispred_i (resolve_mispred),
        .flush_i           (flush),
        .cp_restore_o      (cp_restore),
        .cp_head_o         (cp_head),
        .occupancy_o       (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int find_id(input int id);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].id == id) return i;
        end
        return -1;
    endfunction

    // One cycle: drive after the falling edge, check, advance the model at the rising edge.
    task automatic step(input bit req, input int ahead, input bit rv, input int rid,
                        input bit rm, input bit fl);
        int idx;
        bit mis;
        bit gr;
        bit ret;
        alloc_req       = req;
        alloc_head      = 7'(ahead);
        resolve_valid   = rv;
        resolve_id      = 3'(rid);
        resolve_mispred = rm;
        flush           = fl;
        #1;
        idx = find_id(rid);
        mis = rv && rm && (idx >= 0);
        gr  = req && (q.size() < 8) && !fl && !mis;
        check("grant", 32'(alloc_grant), 32'(gr));
        check("alloc_id", 32'(alloc_id), 32'((mhead + q.size()) % 8));
        check("stall", 32'(stall), 32'(q.size() == 8));
        check("occupancy", 32'(occupancy), 32'(q.size()));
        check("restore", 32'(cp_restore), 32'(exp_restore));
        if (exp_restore) check("cp_head", 32'(cp_head), 32'(exp_head));
        @(posedge clk);
        ret = (q.size() > 0) && q[0].done;
        if (fl) begin
            q.delete();
            mhead       = 0;
            exp_restore = 1'b0;
        end else if (mis) begin
            exp_restore = 1'b1;
            exp_head    = q[idx].snap;
            while (q.size() > idx) void'(q.pop_back());
            if (idx == 0) begin
                mhead = rid;
            end else if (ret) begin
                void'(q.pop_front());
                mhead = (mhead + 1) % 8;
            end
        end else begin
            exp_restore = 1'b0;
            if (rv && idx >= 0) q[idx].done = 1'b1;
            if (ret) begin
                void'(q.pop_front());
                mhead = (mhead + 1) % 8;
            end
            if (gr) q.push_back('{id: (mhead + q.size()) % 8, snap: ahead % 128, done: 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int rid;
        reset           = 1'b1;
        alloc_req       = 1'b0;
        alloc_head      = '0;
        resolve_valid   = 1'b0;
        resolve_id      = '0;
        resolve_mispred = 1'b0;
        flush           = 1'b0;
        mhead           = 0;
        exp_restore     = 1'b0;
        exp_head        = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_occupancy", 32'(occupancy), 32'd0);
        check("reset_restore", 32'(cp_restore), 32'd0);
        check("reset_cp_head", 32'(cp_head), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_alloc_id", 32'(alloc_id), 32'd0);

        $display("[TB] fill ring");
        for (int i = 0; i < 8; i++) step(1, 10 + i, 0, 0, 0, 0);
        check("full_stall", 32'(stall), 32'd1);
        check("full_occupancy", 32'(occupancy), 32'd8);
        step(1, 99, 0, 0, 0, 0);
        check("ninth_occupancy", 32'(occupancy), 32'd8);

        $display("[TB] out-of-order resolve and in-order retire");
        step(0, 0, 1, 3, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("before_retire", 32'(occupancy), 32'd8);
        idle();
        check("after_retire", 32'(occupancy), 32'd7);
        idle();
        check("head_blocked", 32'(occupancy), 32'd7);

        $display("[TB] mispredict restore");
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 20 + i, 0, 0, 0, 0);
        step(0, 0, 1, 2, 1, 0);
        check("mis_restore", 32'(cp_restore), 32'd1);
        check("mis_cp_head", 32'(cp_head), 32'd22);
        check("mis_occupancy", 32'(occupancy), 32'd2);
        check("mis_alloc_id", 32'(alloc_id), 32'd2);
        step(1, 25, 0, 0, 0, 0);
        check("restore_pulse_end", 32'(cp_restore), 32'd0);

        $display("[TB] wrap-around mispredict");
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, i, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, i, 0, 0);
        idle();
        idle();
        check("drained", 32'(occupancy), 32'd0);
        check("drained_alloc_id", 32'(alloc_id), 32'd6);
        for (int i = 0; i < 4; i++) step(1, 30 + i, 0, 0, 0, 0);
        step(0, 0, 1, 7, 1, 0);
        check("wrap_cp_head", 32'(cp_head), 32'd31);
        check("wrap_occupancy", 32'(occupancy), 32'd1);
        check("wrap_alloc_id", 32'(alloc_id), 32'd7);

        $display("[TB] mispredict with same-cycle alloc");
        step(1, 40, 0, 0, 0, 0);
        step(1, 41, 0, 0, 0, 0);
        step(1, 50, 1, 7, 1, 0);
        check("mis_alloc_cp_head", 32'(cp_head), 32'd40);
        check("mis_alloc_occupancy", 32'(occupancy), 32'd1);
        step(0, 0, 1, 0, 0, 0);
        check("squashed_resolve_ignored", 32'(occupancy), 32'd1);
        step(1, 51, 0, 0, 0, 0);

        $display("[TB] flush wins");
        step(1, 52, 0, 0, 0, 0);
        step(1, 53, 0, 0, 0, 0);
        check("pre_flush_occupancy", 32'(occupancy), 32'd4);
        step(1, 54, 1, 7, 1, 1);
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_restore", 32'(cp_restore), 32'd0);
        check("flush_alloc_id", 32'(alloc_id), 32'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            if (q.size() > 0 && $urandom_range(0, 4) != 0) rid = q[$urandom_range(0, q.size() - 1)].id;
            else rid = $urandom_range(0, 7);
            step($urandom_range(0, 9) < 6, $urandom_range(0, 127), $urandom_range(0, 1) == 1,
                 rid, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
